// File: rtl/load_store_unit.sv
// RV64I load/store unit between the multicycle datapath and a 64-bit data memory.
// Aligns and extends load data, read-modify-writes sub-doubleword stores, flags bad accesses.
module load_store_unit #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] rdata,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_wr,
  input  logic [63:0] mem_rdata
);

  localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [2:0]        off_q, off_d;
  logic [63:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [63:0]       rdata_q, rdata_d;
  logic [63:0]       mem_addr_q, mem_addr_d;
  logic [63:0]       mem_wdata_q, mem_wdata_d;
  logic              mem_wr_q, mem_wr_d;

  // Low address bits that must be zero for a naturally aligned access of size 1<<f2.
  function automatic logic [2:0] align_mask(input logic [1:0] f2);
    logic [2:0] m;
    case (f2)
      2'b00:   m = 3'b000;
      2'b01:   m = 3'b001;
      2'b10:   m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

  function automatic logic access_bad(input logic w, input logic [2:0] f3, input logic [2:0] off);
    return (f3 == 3'b111) || (w && f3[2]) || ((off & align_mask(f3[1:0])) != 3'b000);
  endfunction

  function automatic logic [63:0] load_extend(input logic [63:0] dw, input logic [2:0] off,
                                              input logic [2:0] f3);
    logic signed [63:0] sh;
    logic [63:0]        ext;
    sh = dw >> {off, 3'b000};
    case (f3[1:0])
      2'b00:   ext = f3[2] ? {56'd0, sh[7:0]}  : {{56{sh[7]}}, sh[7:0]};
      2'b01:   ext = f3[2] ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'b10:   ext = f3[2] ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: ext = sh;
    endcase
    return ext;
  endfunction

  function automatic logic [63:0] byte_merge(input logic [63:0] dw, input logic [63:0] wd,
                                             input logic [2:0] off, input logic [1:0] f2);
    logic [63:0] sh;
    logic [7:0]  bm;
    logic [63:0] m;
    sh = wd << {off, 3'b000};
    case (f2)
      2'b00:   bm = 8'h01;
      2'b01:   bm = 8'h03;
      2'b10:   bm = 8'h0F;
      default: bm = 8'hFF;
    endcase
    bm = bm << off;
    for (int i = 0; i < 8; i++) begin
      m[i*8 +: 8] = bm[i] ? sh[i*8 +: 8] : dw[i*8 +: 8];
    end
    return m;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    done_d      = 1'b0;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d       = we;
          funct3_d   = funct3;
          off_d      = addr[2:0];
          wdata_d    = wdata;
          mem_addr_d = {addr[63:3], 3'b000};
          err_d      = access_bad(we, funct3, addr[2:0]);
          if (access_bad(we, funct3, addr[2:0])) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (we && (funct3[1:0] == 2'b11)) begin
            // Full-doubleword store needs no read; write straight away.
            state_d     = WR;
            mem_wdata_d = wdata;
            mem_wr_d    = 1'b1;
          end else begin
            state_d = RD;
            cnt_d   = CNT_INIT;
          end
        end
      end
      RD: begin
        if (cnt_q == CNT_ONE) begin
          if (we_q) begin
            state_d     = WR;
            mem_wdata_d = byte_merge(mem_rdata, wdata_q, off_q, funct3_q[1:0]);
            mem_wr_d    = 1'b1;
          end else begin
            state_d = DONE;
            rdata_d = load_extend(mem_rdata, off_q, funct3_q);
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      WR: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
    end
  end

  // Request operands are only meaningful once accepted, so they carry no reset.
  always_ff @(posedge clk) begin
    we_q     <= we_d;
    funct3_q <= funct3_d;
    off_q    <= off_d;
    wdata_q  <= wdata_d;
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and random accesses on MEM_LAT=1 and MEM_LAT=3 instances,
// checked against a byte-array memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req3 = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [63:0] addr = '0, wdata = '0;

  logic        busy0, done0, err0, mem_wr0;
  logic [63:0] rdata0, mem_addr0, mem_wdata0, mem_rdata0;
  logic        busy3, done3, err3, mem_wr3;
  logic [63:0] rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  logic [7:0]  mem [0:63];
  logic [7:0]  ref_mem [0:63];
  logic        ld_en = 1'b0;
  int          ld_idx = 0;
  logic [7:0]  ld_byte = '0;
  int          wr_total = 0;

  logic [63:0] ref_rd0 = '0, ref_rd3 = '0;
  int          n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_LAT(1)) u0 (
    .clk(clk), .reset(reset), .req(req0), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
    .busy(busy0), .done(done0), .err(err0), .rdata(rdata0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_wr(mem_wr0), .mem_rdata(mem_rdata0));

  load_store_unit #(.MEM_LAT(3)) u3 (
    .clk(clk), .reset(reset), .req(req3), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
    .busy(busy3), .done(done3), .err(err3), .rdata(rdata3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_wr(mem_wr3), .mem_rdata(mem_rdata3));

  // Memory: only u0 writes; both instances read through their own address.
  always @(posedge clk) begin
    if (mem_wr0) begin
      for (int i = 0; i < 8; i++) mem[int'(mem_addr0[5:3]) * 8 + i] <= mem_wdata0[i*8 +: 8];
      wr_total <= wr_total + 1;
    end else if (ld_en) begin
      mem[ld_idx] <= ld_byte;
    end
  end

  always_comb begin
    mem_rdata0 = '0;
    mem_rdata3 = '0;
    for (int i = 0; i < 8; i++) begin
      mem_rdata0[i*8 +: 8] = mem[int'(mem_addr0[5:3]) * 8 + i];
      mem_rdata3[i*8 +: 8] = mem[int'(mem_addr3[5:3]) * 8 + i];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_load(input int a, input logic [2:0] f);
    int sz;
    logic [63:0] v;
    sz = 1 << f[1:0];
    v = '0;
    for (int i = 0; i < sz; i++) v[i*8 +: 8] = ref_mem[a + i];
    if (!f[2] && sz < 8 && v[sz*8 - 1])
      for (int i = sz * 8; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic check_mem(input string tag);
    int diffs = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check(tag, 64'(diffs), 64'd0);
  endtask

  task automatic access(input bit sel, input bit w, input logic [2:0] f, input int a,
                        input logic [63:0] d, input bit hold, input string tag);
    int sz, lat, lat_exp, wr_before, lat_mem;
    bit bad, seen;
    logic err_o;
    logic [63:0] rd_o;
    sz = 1 << f[1:0];
    lat_mem = sel ? 3 : 1;
    bad = ((a % sz) != 0) || (f == 3'b111) || (w && f[2]);
    lat_exp = bad ? 1 : (w ? ((f[1:0] == 2'b11) ? 2 : lat_mem + 2) : lat_mem + 1);
    if (!bad && !w) begin
      if (sel) ref_rd3 = model_load(a, f);
      else     ref_rd0 = model_load(a, f);
    end
    wr_before = wr_total;
    @(negedge clk);
    we = w; funct3 = f; addr = 64'(a); wdata = d;
    if (sel) req3 = 1'b1; else req0 = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin req0 = 1'b0; req3 = 1'b0; end
    seen = 0; lat = 0; err_o = 1'bx; rd_o = 'x;
    for (int k = 1; k <= 12 && !seen; k++) begin
      @(negedge clk);
      if (sel ? done3 : done0) begin
        seen = 1; lat = k;
        err_o = sel ? err3 : err0;
        rd_o  = sel ? rdata3 : rdata0;
      end
    end
    req0 = 1'b0; req3 = 1'b0;
    if (!bad && w) for (int i = 0; i < sz; i++) ref_mem[a + i] = d[i*8 +: 8];
    check({tag, "_lat"}, 64'(lat), 64'(lat_exp));
    check({tag, "_err"}, {63'd0, err_o}, {63'd0, bad});
    check({tag, "_rdata"}, rd_o, sel ? ref_rd3 : ref_rd0);
    @(negedge clk);
    check({tag, "_idle"}, {62'd0, (sel ? busy3 : busy0), (sel ? done3 : done0)}, 64'd0);
    check({tag, "_wrs"}, 64'(wr_total - wr_before), 64'((!bad && w) ? 1 : 0));
    check_mem({tag, "_mem"});
  endtask

  initial begin
    int f, w, a, sz;
    logic [63:0] dw;
    // Preload memory while reset is held.
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_idx = i;
      ld_byte = (i >= 16 && i < 24) ? 8'((i - 15) * 8'h11) : 8'($urandom);
      ref_mem[i] = ld_byte;
    end
    @(negedge clk);
    ld_en = 1'b0;
    check("rst_busy", {63'd0, busy0}, 64'd0);
    check("rst_done_err_wr", {61'd0, done0, err0, mem_wr0}, 64'd0);
    check("rst_rdata", rdata0, 64'd0);
    check("rst_mem_addr", mem_addr0, 64'd0);
    check("rst_mem_wdata", mem_wdata0, 64'd0);
    check_mem("preload");
    reset = 1'b0;

    access(0, 0, 3'b000, 'h17, '0, 0, "lb17");
    check("lb17_val", rdata0, 64'hFFFFFFFFFFFFFF88);
    access(0, 0, 3'b100, 'h17, '0, 0, "lbu17");
    check("lbu17_val", rdata0, 64'h88);
    access(0, 0, 3'b001, 'h16, '0, 0, "lh16");
    check("lh16_val", rdata0, 64'hFFFFFFFFFFFF8877);
    access(0, 0, 3'b010, 'h14, '0, 0, "lw14");
    access(0, 0, 3'b110, 'h14, '0, 0, "lwu14");
    check("lwu14_val", rdata0, 64'h88776655);
    access(0, 0, 3'b011, 'h10, '0, 0, "ld10");
    access(0, 1, 3'b000, 'h11, 64'hAB, 0, "sb11");
    for (int i = 0; i < 8; i++) dw[i*8 +: 8] = mem[16 + i];
    check("sb11_dword", dw, 64'h887766554433AB11);
    access(0, 1, 3'b011, 'h10, 64'h0123456789ABCDEF, 0, "sd10");
    for (int i = 0; i < 8; i++) dw[i*8 +: 8] = mem[16 + i];
    check("sd10_dword", dw, 64'h0123456789ABCDEF);
    access(0, 1, 3'b001, 'h13, 64'h5555, 0, "sh13_mis");
    access(0, 0, 3'b010, 'h12, '0, 0, "lw12_mis");
    access(0, 0, 3'b111, 'h08, '0, 0, "ld_ill");
    access(0, 1, 3'b110, 'h08, 64'h1234, 0, "st_ill");
    access(0, 0, 3'b001, 'h1E, '0, 1, "lh_hold");
    access(0, 1, 3'b010, 'h24, 64'hDEADBEEF, 1, "sw_hold");

    access(1, 0, 3'b000, 'h17, '0, 0, "l3_lb");
    access(1, 0, 3'b010, 'h24, '0, 0, "l3_lw");
    access(1, 0, 3'b011, 'h10, '0, 1, "l3_ld_hold");

    // Reset while an sw is reading: aborted, no write.
    begin
      int wr_before;
      wr_before = wr_total;
      @(negedge clk);
      we = 1'b1; funct3 = 3'b010; addr = 64'h20; wdata = 64'hCAFEF00D; req0 = 1'b1;
      @(posedge clk);
      #1 req0 = 1'b0;
      @(negedge clk);
      check("rst_rd_busy", {63'd0, busy0}, 64'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_rd_idle", {62'd0, busy0, mem_wr0}, 64'd0);
      check("rst_rd_rdata", rdata0, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      ref_rd0 = '0; ref_rd3 = '0;
      repeat (3) @(negedge clk);
      check("rst_rd_wrs", 64'(wr_total - wr_before), 64'd0);
      check_mem("rst_rd_mem");
    end

    for (int n = 0; n < 40; n++) begin
      f = $urandom_range(0, 7);
      w = $urandom_range(0, 1);
      sz = 1 << f[1:0];
      a = $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0) a = a & ~(sz - 1);
      access(0, w[0], f[2:0], a, {$urandom, $urandom}, 0, "rnd");
    end
    for (int n = 0; n < 6; n++) begin
      f = $urandom_range(0, 6);
      sz = 1 << f[1:0];
      a = $urandom_range(0, 63) & ~(sz - 1);
      access(1, 0, f[2:0], a, '0, 0, "rnd3");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
